// File: rtl/button_debounce_pkg.sv
// Shared types and constants for the multi-channel push-button debouncer.
package button_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ARM_PRESS   = 2'd1,
    HELD        = 2'd2,
    ARM_RELEASE = 2'd3
  } deb_state_t;

  // 1 ms of stability at a 50 MHz clock
  localparam int DEFAULT_STABLE_CYCLES = 50000;

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: 2-flop synchronizer, stability FSM with counter,
// registered level output and press/release strobes.
module debounce_channel
  import button_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_out,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(STABLE_CYCLES - 1);

  logic sync_meta;
  logic sync_stable;
  logic sample;

  deb_state_t state;
  deb_state_t next_state;
  logic [CW-1:0] count;
  logic [CW-1:0] next_count;

  // Synchronizer resets to the released raw level so deassertion never looks like a press
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta   <= ACTIVE_LOW;
      sync_stable <= ACTIVE_LOW;
    end else begin
      sync_meta   <= key_raw;
      sync_stable <= sync_meta;
    end
  end

  assign sample = sync_stable ^ ACTIVE_LOW;

  always_comb begin
    next_state = state;
    next_count = count;
    unique case (state)
      IDLE: begin
        if (sample) begin
          next_state = ARM_PRESS;
          next_count = CW'(1);
        end
      end
      ARM_PRESS: begin
        if (!sample) begin
          next_state = IDLE;
          next_count = '0;
        end else if (count == LAST_COUNT) begin
          next_state = HELD;
          next_count = '0;
        end else begin
          next_count = count + CW'(1);
        end
      end
      HELD: begin
        if (!sample) begin
          next_state = ARM_RELEASE;
          next_count = CW'(1);
        end
      end
      ARM_RELEASE: begin
        if (sample) begin
          next_state = HELD;
          next_count = '0;
        end else if (count == LAST_COUNT) begin
          next_state = IDLE;
          next_count = '0;
        end else begin
          next_count = count + CW'(1);
        end
      end
      default: begin
        next_state = IDLE;
        next_count = '0;
      end
    endcase
  end

  // Outputs are decoded from next_state so they change on the same edge as the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      count         <= '0;
      key_out       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= next_state;
      count         <= next_count;
      key_out       <= (next_state == HELD) || (next_state == ARM_RELEASE);
      press_pulse   <= (state == ARM_PRESS) && (next_state == HELD);
      release_pulse <= (state == ARM_RELEASE) && (next_state == IDLE);
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Multi-channel button debouncer: one independent debounce_channel per key bit.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] key_in,
  output logic [WIDTH-1:0] key_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW != 0)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .key_raw      (key_in[i]),
      .key_out      (key_out[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce (4 channels, STABLE_CYCLES=4, active-low keys).
module tb_button_debounce;

  localparam int W = 4;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] key_in;
  logic [W-1:0] key_out;
  logic [W-1:0] press_pulse;
  logic [W-1:0] release_pulse;

  typedef struct packed {
    logic [W-1:0] k;
    logic [W-1:0] p;
    logic [W-1:0] r;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  logic [W-1:0] m1, m2, kout;
  int run[W];
  int press_cnt[W];
  int release_cnt[W];
  int last_press_edge[W];
  int last_release_edge[W];
  int all_press_cnt;
  int t0;
  int t1;

  always #5 clk = ~clk;

  button_debounce #(
    .WIDTH(W),
    .STABLE_CYCLES(S),
    .ACTIVE_LOW(1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_in       (key_in),
    .key_out      (key_out),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic clearCounts();
    for (int i = 0; i < W; i++) begin
      press_cnt[i] = 0;
      release_cnt[i] = 0;
      last_press_edge[i] = -1;
      last_release_edge[i] = -1;
    end
    all_press_cnt = 0;
  endtask

  // Called just after a falling edge: drives one cycle, predicts, then checks after the rising edge
  task automatic applyStimulus(input logic [W-1:0] val, input logic rst_val);
    logic [W-1:0] sample;
    logic [W-1:0] p;
    logic [W-1:0] r;
    exp_t e;
    key_in = val;
    reset  = rst_val;
    p = '0;
    r = '0;
    if (rst_val) begin
      m1 = '0;
      m2 = '0;
      kout = '0;
      for (int i = 0; i < W; i++) run[i] = 0;
    end else begin
      sample = m2;
      m2 = m1;
      m1 = ~val;
      for (int i = 0; i < W; i++) begin
        if (sample[i] != kout[i]) begin
          run[i]++;
          if (run[i] == S) begin
            kout[i] = ~kout[i];
            run[i] = 0;
            if (kout[i]) p[i] = 1'b1;
            else r[i] = 1'b1;
          end
        end else begin
          run[i] = 0;
        end
      end
    end
    exp_q.push_back('{k: kout, p: p, r: r});
    if (rst_val) begin
      #1;
      checkOutput("reset_immediate", {20'd0, key_out, press_pulse, release_pulse}, 32'd0);
    end
    @(posedge clk);
    edge_n++;
    #1;
    e = exp_q.pop_front();
    checkOutput("key_out", {28'd0, key_out}, {28'd0, e.k});
    checkOutput("press_pulse", {28'd0, press_pulse}, {28'd0, e.p});
    checkOutput("release_pulse", {28'd0, release_pulse}, {28'd0, e.r});
    for (int i = 0; i < W; i++) begin
      if (press_pulse[i] === 1'b1) begin
        press_cnt[i]++;
        last_press_edge[i] = edge_n;
      end
      if (release_pulse[i] === 1'b1) begin
        release_cnt[i]++;
        last_release_edge[i] = edge_n;
      end
    end
    if (press_pulse === 4'hF) all_press_cnt++;
    @(negedge clk);
  endtask

  task automatic hold(input logic [W-1:0] val, input int n);
    for (int c = 0; c < n; c++) applyStimulus(val, 1'b0);
  endtask

  initial begin
    int sum;
    reset  = 1'b1;
    key_in = 4'hF;
    m1 = '0;
    m2 = '0;
    kout = '0;
    for (int i = 0; i < W; i++) run[i] = 0;
    clearCounts();
    @(negedge clk);

    // Reset with all keys released, then idle
    applyStimulus(4'hF, 1'b1);
    applyStimulus(4'hF, 1'b1);
    clearCounts();
    hold(4'hF, 20);
    sum = 0;
    for (int i = 0; i < W; i++) sum += press_cnt[i] + release_cnt[i];
    checkOutput("idle_no_pulse", sum, 0);
    checkOutput("idle_key_out", {28'd0, key_out}, 32'h0);

    // Clean press on bit0
    clearCounts();
    t0 = edge_n;
    hold(4'hE, 10);
    checkOutput("press0_latency", last_press_edge[0] - t0, 6);
    checkOutput("press0_count", press_cnt[0], 1);
    checkOutput("press0_key_out", {28'd0, key_out}, 32'h1);

    // Bouncing press on bit1
    clearCounts();
    hold(4'hC, 3);
    hold(4'hE, 1);
    t1 = edge_n;
    hold(4'hC, 12);
    checkOutput("bounce1_count", press_cnt[1], 1);
    checkOutput("bounce1_latency", last_press_edge[1] - t1, 6);

    // Short release glitch on bit0 is rejected, then a real release
    clearCounts();
    hold(4'hD, 2);
    hold(4'hC, 10);
    checkOutput("glitch0_no_release", release_cnt[0], 0);
    checkOutput("glitch0_key_out", {31'd0, key_out[0]}, 32'h1);
    t0 = edge_n;
    hold(4'hD, 12);
    checkOutput("release0_count", release_cnt[0], 1);
    checkOutput("release0_latency", last_release_edge[0] - t0, 6);

    // Reset mid-count on bit2 while bit1 is held
    clearCounts();
    hold(4'h9, 5);
    applyStimulus(4'h9, 1'b1);
    applyStimulus(4'h9, 1'b1);
    checkOutput("rst_no_release1", release_cnt[1], 0);
    checkOutput("rst_no_press2", press_cnt[2], 0);
    t0 = edge_n;
    hold(4'h9, 10);
    checkOutput("repress2_latency", last_press_edge[2] - t0, 6);
    checkOutput("repress2_count", press_cnt[2], 1);
    checkOutput("rst_release1_never", release_cnt[1], 0);

    // All channels released, then all pressed together
    hold(4'hF, 12);
    clearCounts();
    t0 = edge_n;
    hold(4'h0, 10);
    checkOutput("all_press_once", all_press_cnt, 1);
    checkOutput("all_press_latency", last_press_edge[3] - t0, 6);
    checkOutput("all_key_out", {28'd0, key_out}, 32'hF);

    checkOutput("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter WIDTH, default 4, number of independent button channels.
REQ-002 Parameter STABLE_CYCLES, default 50000 (1 ms at 50 MHz), consecutive stable cycles required to accept a level change; legal range 2 to 2^20.
REQ-003 Parameter ACTIVE_LOW, default 1, raw input polarity; 1 means raw 0 = pressed.
REQ-004 clk  input  1  sole clock; all flops rising-edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 key_in  input  WIDTH  raw, asynchronous, bouncing button levels.
REQ-007 key_out  output  WIDTH  debounced level, 1 = pressed; drives the PIO in_port directly.
REQ-008 press_pulse  output  WIDTH  one-cycle strobe per channel on an accepted press.
REQ-009 release_pulse  output  WIDTH  one-cycle strobe per channel on an accepted release.

Function
REQ-010 Each key_in bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 The synchronized bit SHALL be normalized (XOR with ACTIVE_LOW) so that 1 = pressed.
REQ-012 Each channel SHALL run an independent FSM with states IDLE (released), ARM_PRESS, HELD (pressed) and ARM_RELEASE.
REQ-013 IDLE -> ARM_PRESS when the normalized sample is 1; the counter loads 1.
REQ-014 ARM_PRESS: sample 1 increments the counter; sample 0 returns to IDLE with the counter cleared.
REQ-015 ARM_PRESS -> HELD on the edge at which the counter would reach STABLE_CYCLES; the counter clears.
REQ-016 HELD -> ARM_RELEASE when the sample is 0; ARM_RELEASE mirrors ARM_PRESS with inverted sense and ends in IDLE.
REQ-017 key_out SHALL be registered: 1 in HELD and ARM_RELEASE, 0 in IDLE and ARM_PRESS.
REQ-018 press_pulse SHALL be high for exactly the first cycle key_out is 1; release_pulse SHALL be high for exactly the first cycle key_out is 0 after HELD.
REQ-019 Latency from a clean raw transition to the key_out change SHALL be exactly STABLE_CYCLES+2 clock edges (2 synchronizer edges plus STABLE_CYCLES).
REQ-020 Any opposite sample during ARM_* SHALL abort the attempt; no partial credit is kept, and the next attempt restarts from 1.
REQ-021 The counter width SHALL be $clog2(STABLE_CYCLES+1) and it SHALL never wrap; it saturates logically by leaving ARM_*.
REQ-022 Channels SHALL be fully independent; simultaneous changes on several bits produce simultaneous pulses on those bits.
REQ-023 A channel held constant SHALL never pulse, whatever the activity on other channels.

Reset
REQ-024 While reset is high, synchronizer flops SHALL hold the released raw level (1 when ACTIVE_LOW, else 0), so no false press occurs at deassertion.
REQ-025 While reset is high, FSMs SHALL be IDLE, counters 0, and key_out, press_pulse and release_pulse all 0.
REQ-026 Reset asserted mid-count or in HELD SHALL abandon the state immediately, with no release_pulse.

Structure
REQ-027 Package button_debounce_pkg SHALL hold the FSM state typedef (2-bit enum) and the default STABLE_CYCLES constant.
REQ-028 Per-channel logic (synchronizer, FSM, counter, pulse regs) SHALL be sub-module debounce_channel, instantiated WIDTH times in a generate loop.
REQ-029 The top level SHALL contain no logic beyond instantiation and bus concatenation.

Verification (STABLE_CYCLES=4, ACTIVE_LOW=1)
REQ-030 Reset with key_in=4'hF, then deassert -> key_out=0, with no pulse for 20 cycles.
REQ-031 key_in 4'hF -> 4'hE held -> key_out=4'h1 exactly 6 edges later, and press_pulse=4'h1 for one cycle in that same cycle.
REQ-032 key_in[1] low 3 cycles, high 1 cycle, then low steady -> exactly one press_pulse[1], 6 edges after the final transition.
REQ-033 From HELD on bit0, key_in[0] high 2 cycles then low -> key_out[0] stays 1, with no release_pulse; then high steady -> release_pulse[0] 6 edges later.
REQ-034 Bit2 pressed and reset pulsed at count 3 -> after reset, key_out=0, with no pulses; a re-press needs the full 6 edges.
REQ-035 key_in 4'hF -> 4'h0 at once -> press_pulse=4'hF in a single cycle, and key_out=4'hF.
